fifo_rd_stream: RTL



---
 rtl/fifo_rd_stream_pkg.sv | 7 +
 rtl/fifo_rd_skid.sv | 47 ++++
 rtl/fifo_rd_stream.sv | 53 +++++
 3 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared defaults for the FIFO read-side stream adapter.
package fifo_rd_stream_pkg;

  localparam int unsigned FRS_DATA_WIDTH = 8;
  localparam int unsigned FRS_SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_skid.sv
// Circular skid buffer: write at tail, pop at head, head word and occupancy exposed.
module fifo_rd_skid
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FRS_DATA_WIDTH,
  parameter int unsigned SKID_DEPTH = FRS_SKID_DEPTH,
  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_W-1:0]      count
);

  localparam int unsigned PTR_W = $clog2(SKID_DEPTH);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  // Pointers wrap modulo SKID_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= ptr_inc(tail);
      if (pop)   head <= ptr_inc(head);
      count <= count + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= wr_data;
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// Credit-based FIFO read issue with one-cycle read latency, feeding a skid buffer onto a valid/ready stream.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FRS_DATA_WIDTH,
  parameter int unsigned SKID_DEPTH = FRS_SKID_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;

  logic             pend;
  logic             pop;
  logic [CNT_W-1:0] occ;
  logic [CRD_W-1:0] credit_c;

  assign m_valid = rst_n & (occ != '0);
  assign pop     = m_valid & m_ready;
  assign busy    = rst_n & (pend | (occ != '0));

  // Words already held or in flight, net of this cycle's pop, must leave room for one more.
  assign credit_c   = {1'b0, occ} + CRD_W'(pend) - CRD_W'(pop);
  assign fifo_rd_en = rst_n & ~fifo_empty & (credit_c < CRD_W'(SKID_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) pend <= 1'b0;
    else        pend <= fifo_rd_en;
  end

  fifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH),
    .SKID_DEPTH(SKID_DEPTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (pend),
    .wr_data  (fifo_data),
    .pop      (pop),
    .head_data(m_data),
    .count    (occ)
  );

endmodule
